tone_sequencer: RTL and testbench

//  Upstream driver for the speaker tone generator. Turns one-cycle game-event

---
 rtl/tone_sequencer.sv | 85 ++++++++
 tb/tb_tone_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: turns game-event pulses into timed note sequences for the speaker; `define SND_PREEMPT_EN lets a win abort a move/invalid sequence
module tone_sequencer #(
  parameter int HP_W       = 18,
  parameter int NOTE_TICKS = 5_000_000,
  parameter int GAP_TICKS  = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            evt_move,
  input  logic            evt_invalid,
  input  logic            evt_win,
  output logic [HP_W-1:0] tone_half_period,
  output logic            tone_en,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(NOTE_TICKS > GAP_TICKS ? NOTE_TICKS : GAP_TICKS) + 1;
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;
  localparam logic [1:0] MEL_MOVE = 2'd0, MEL_INV = 2'd1, MEL_WIN = 2'd2;
  logic [1:0]    state_q, state_d, mel_q, mel_d, note_q, note_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          done_d, start, preempt, last, en_d;
  logic [HP_W-1:0] hp_d;
  function automatic logic [HP_W-1:0] rom_hp(input logic [1:0] m, input logic [1:0] n);
    return m == MEL_WIN ? (n == 2'd0 ? HP_W'(47801) : n == 2'd1 ? HP_W'(37936) :
                           n == 2'd2 ? HP_W'(31888) : HP_W'(23877)) :
           m == MEL_INV ? HP_W'(113636) : HP_W'(31888);
  endfunction
  assign start = (state_q == IDLE) & (evt_move | evt_invalid | evt_win);
`ifdef SND_PREEMPT_EN
  assign preempt = evt_win & (state_q != IDLE) & (mel_q != MEL_WIN);
`else
  assign preempt = 1'b0;
`endif
  assign last = note_q == (mel_q == MEL_WIN ? 2'd3 : mel_q == MEL_INV ? 2'd1 : 2'd0);
  // next-state: event start/preempt, note/gap timeouts, tick countdown
  always_comb begin
    state_d = state_q;
    mel_d   = mel_q;
    note_d  = note_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    if (start | preempt) begin
      state_d = PLAY;
      mel_d   = evt_win ? MEL_WIN : evt_invalid ? MEL_INV : MEL_MOVE;
      note_d  = 2'd0;
      tick_d  = CW'(NOTE_TICKS - 1);
    end else if (state_q == PLAY && tick_q == '0) begin
      state_d = last ? IDLE : GAP;
      note_d  = last ? 2'd0 : note_q;
      tick_d  = last ? '0 : CW'(GAP_TICKS - 1);
      done_d  = last;
    end else if (state_q == GAP && tick_q == '0) begin
      state_d = PLAY;
      note_d  = note_q + 2'd1;
      tick_d  = CW'(NOTE_TICKS - 1);
    end else if (tick_q != '0) begin
      tick_d  = tick_q - CW'(1);
    end
    en_d = state_d == PLAY;
    hp_d = en_d ? rom_hp(mel_d, note_d) : '0;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      mel_q            <= MEL_MOVE;
      note_q           <= 2'd0;
      tick_q           <= '0;
      tone_half_period <= '0;
      tone_en          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      mel_q            <= mel_d;
      note_q           <= note_d;
      tick_q           <= tick_d;
      tone_half_period <= hp_d;
      tone_en          <= en_d;
      busy             <= state_d != IDLE;
      done             <= done_d;
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table vectors, spec-timeline sequences and random events against a timeline model
module tb_tone_sequencer;
  localparam int NT = 4, GT = 2, HW = 18;
  logic clk = 1'b0, rst = 1'b0, mv = 1'b0, inv = 1'b0, win = 1'b0;
  logic [HW-1:0] hp;
  logic en, busy, done;
  always #5 clk = ~clk;
  tone_sequencer #(.HP_W(HW), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .evt_move(mv), .evt_invalid(inv), .evt_win(win),
    .tone_half_period(hp), .tone_en(en), .busy(busy), .done(done));

  typedef struct {bit m, i, w; bit en; int hp; bit busy, done;} vec_t;
  vec_t tbl[6];
  int checks = 0, fails = 0, cyc = 0;
  bit m_act = 0, m_done = 0;
  int m_mel = 0, m_start = 0;
  int rom[3][4] = '{'{31888, 0, 0, 0}, '{113636, 113636, 0, 0}, '{47801, 37936, 31888, 23877}};
  int cnt[3] = '{1, 2, 4};

  function automatic int total(int m);
    return cnt[m] * NT + (cnt[m] - 1) * GT;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // sequence timeline: note k plays over [k*(NT+GT), k*(NT+GT)+NT) after start
  task automatic model_edge(bit m, bit i, bit w);
    bit wb;
    wb = m_act;
    m_done = 0;
    if (m_act && cyc - m_start == total(m_mel)) begin
      m_act = 0;
      m_done = 1;
    end
    if (!wb && (m | i | w)) begin
      m_act = 1; m_mel = w ? 2 : i ? 1 : 0; m_start = cyc;
    end
`ifdef SND_PREEMPT_EN
    else if (wb && w && m_mel != 2) begin
      m_act = 1; m_mel = 2; m_start = cyc; m_done = 0;
    end
`endif
  endtask

  task automatic check_model();
    int e, k;
    bit pe;
    int ph;
    e = cyc - m_start;
    k = e / (NT + GT);
    pe = m_act && (e % (NT + GT)) < NT;
    ph = pe ? rom[m_mel][k] : 0;
    check("model_tone_en", en, pe);
    check("model_half_period", hp, ph);
    check("model_busy", busy, m_act);
    check("model_done", done, m_done);
  endtask

  task automatic step(bit m, bit i, bit w);
    mv = m; inv = i; win = w;
    @(posedge clk);
    cyc++;
    model_edge(m, i, w);
    #1;
    check_model();
    mv = 0; inv = 0; win = 0;
  endtask

  task automatic run_table();
    foreach (tbl[n]) begin
      step(tbl[n].m, tbl[n].i, tbl[n].w);
      check("tbl_en", en, tbl[n].en);
      check("tbl_hp", hp, tbl[n].hp);
      check("tbl_busy", busy, tbl[n].busy);
      check("tbl_done", done, tbl[n].done);
    end
  endtask

  task automatic win_melody(bit with_move);
    int h;
    for (int k = 1; k <= 24; k++) begin
      step(k == 1 ? with_move : 1'b0, 1'b0, k == 1);
      h = (k >= 1 && k <= 4) ? 47801 : (k >= 7 && k <= 10) ? 37936 :
          (k >= 13 && k <= 16) ? 31888 : (k >= 19 && k <= 22) ? 23877 : 0;
      check("win_hp", hp, h);
      check("win_en", en, h != 0);
      check("win_done", done, k == 23);
    end
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 1, 31888, 1, 0};
    for (int n = 1; n < 4; n++) tbl[n] = '{0, 0, 0, 1, 31888, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0};
    #12;
    check("reset_en", en, 0);
    check("reset_hp", hp, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1 rst = 1;
    run_table();
    win_melody(1'b0);
    win_melody(1'b1);
    // move interrupted by win mid-note
    for (int k = 1; k <= 26; k++) begin
      step(k == 1, 1'b0, k == 3);
`ifdef SND_PREEMPT_EN
      if (k == 3) check("pre_hp", hp, 47801);
      if (k == 5) check("pre_done5", done, 0);
      if (k == 25) check("pre_done25", done, 1);
`else
      if (k == 3) check("nopre_hp", hp, 31888);
      if (k == 5) check("nopre_done5", done, 1);
      if (k == 7) check("nopre_busy7", busy, 0);
`endif
    end
    // invalid during move is dropped in both builds
    for (int k = 1; k <= 6; k++) begin
      step(k == 1, k == 3, 1'b0);
      if (k == 3) check("drop_inv_hp", hp, 31888);
      if (k == 5) check("drop_inv_done", done, 1);
      if (k == 6) check("drop_inv_busy", busy, 0);
    end
    // reset mid-sequence silences immediately
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    #2 rst = 0;
    #1;
    check("rst_mid_en", en, 0);
    check("rst_mid_hp", hp, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    m_act = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    run_table();
    // random events against the timeline model
    for (int n = 0; n < 400; n++)
      step($urandom_range(7) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0);
    repeat (30) step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
